// File: rtl/uart_pkg.sv
// uart_pkg
// Definitions shared by the UART receive deframer and the transmit framer:
//   - uart_state_t   : frame state encoding (IDLE/START/DATA/PARITY/STOP)
//   - DATA_BITS_DEF  : default data bits per frame
//   - OVERSAMPLE_DEF : default baud_tick pulses per bit period
//   - LINE_IDLE      : level of an idle serial line
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    localparam int   DATA_BITS_DEF  = 8;
    localparam int   OVERSAMPLE_DEF = 16;
    localparam logic LINE_IDLE      = 1'b1;

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync
// Two-flop synchroniser for the asynchronous rx line plus falling-edge detect.
// Ports:
//   clk  in  : system clock
//   rst  in  : synchronous active-high reset (all flops go to the idle level)
//   rx   in  : asynchronous serial input
//   rx_s out : synchronised rx
//   fall out : rx_s went 1 -> 0 on the last clk edge (combinational)
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rx_s,
    output logic fall
);

    logic rx_m;
    logic rx_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m <= LINE_IDLE;
            rx_s <= LINE_IDLE;
            rx_d <= LINE_IDLE;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            rx_d <= rx_s;
        end
    end

    // A genuine 1->0 transition is required; a line stuck low never retriggers.
    assign fall = rx_d & ~rx_s;

endmodule

// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer
// UART receive front end: oversamples rx with the baud tick, reassembles one
// frame (start, DATA_BITS data LSB first, optional parity, stop) and presents
// the raw sampled fields with a one-clk def_en strobe. No error judgement.
// Ports:
//   clk        in  : system clock
//   rst        in  : synchronous active-high reset
//   baud_tick  in  : one-clk pulse at OVERSAMPLE x baud
//   rx         in  : asynchronous serial input, idle high
//   parity_en  in  : frame carries a parity bit (latched at start detection)
//   data_out   out : captured data, bit0 = first received
//   start_bit  out : sampled start bit
//   parity_bit out : sampled parity bit, 0 when parity disabled
//   stop_bit   out : sampled stop bit
//   def_en     out : one-clk pulse, frame fields valid
//   rx_busy    out : high from start detection until the stop sample
module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DATA_BITS_DEF,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 rx,
    input  logic                 parity_en,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 start_bit,
    output logic                 parity_bit,
    output logic                 stop_bit,
    output logic                 def_en,
    output logic                 rx_busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    uart_state_t          state;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 start_q;
    logic                 par_q;
    logic                 par_en_q;

    logic rx_s;
    logic fall;
    logic mid_tick;
    logic end_tick;

    uart_rx_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .rx   (rx),
        .rx_s (rx_s),
        .fall (fall)
    );

    assign mid_tick = baud_tick && (tick_cnt == TICK_MID);
    assign end_tick = baud_tick && (tick_cnt == TICK_END);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            start_q    <= 1'b0;
            par_q      <= 1'b0;
            par_en_q   <= 1'b0;
            data_out   <= '0;
            start_bit  <= 1'b0;
            parity_bit <= 1'b0;
            stop_bit   <= LINE_IDLE;
            def_en     <= 1'b0;
            rx_busy    <= 1'b0;
        end else begin
            def_en <= 1'b0;

            // Ticks seen in IDLE are ignored; the count restarts at each start edge.
            if (state != IDLE && baud_tick) begin
                tick_cnt <= end_tick ? '0 : tick_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (fall) begin
                        state    <= START;
                        tick_cnt <= '0;
                        rx_busy  <= 1'b1;
                        par_en_q <= parity_en;
                        par_q    <= 1'b0;
                    end
                end

                START: begin
                    // A high start sample is kept, not aborted, so the checker sees it.
                    if (mid_tick) start_q <= rx_s;
                    if (end_tick) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                    end
                end

                DATA: begin
                    if (mid_tick) shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
                    if (end_tick) begin
                        if (bit_cnt == BIT_LAST) begin
                            state <= par_en_q ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end

                PARITY: begin
                    if (mid_tick) par_q <= rx_s;
                    if (end_tick) state <= STOP;
                end

                STOP: begin
                    // Deliver at the stop mid-sample so a following start edge is caught.
                    if (mid_tick) begin
                        data_out   <= shift_reg;
                        start_bit  <= start_q;
                        parity_bit <= par_q;
                        stop_bit   <= rx_s;
                        def_en     <= 1'b1;
                        rx_busy    <= 1'b0;
                        state      <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
Serial-to-parallel receive front end of the full-duplex UART. It oversamples the `rx` line using the 16x baud tick from the baud generator and reassembles one frame: start bit, DATA_BITS data bits sent LSB first, an optional parity bit, and a stop bit. It presents the captured fields together with a one-cycle `def_en` pulse. These outputs go directly to the downstream parity/framing checker (`start`, `stop`, `parity`, `def_en`, `data_in` inputs). The block does no error judgement; it reports raw sampled bits only.

Parameters:
DATA_BITS, 8, data bits per frame
OVERSAMPLE, 16, baud_tick pulses per bit period (even, >=4)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
baud_tick  in  1  one-clk pulse at OVERSAMPLE x baud rate
rx  in  1  asynchronous serial input, idle high
parity_en  in  1  1 = frame carries a parity bit; sampled at start detection
data_out  out  DATA_BITS  captured data, bit0 = first received
start_bit  out  1  sampled start-bit value (0 expected)
parity_bit  out  1  sampled parity bit; 0 when parity disabled
stop_bit  out  1  sampled stop-bit value (1 expected)
def_en  out  1  one-clk pulse: frame complete, outputs valid
rx_busy  out  1  high from start detection until stop sample

Behaviour:
- Synchroniser: 2-FF on `rx`, both FFs reset to 1. All logic uses `rx_s`, and `rx_d` is `rx_s` delayed one clk (also reset to 1).
- Reset (rst=1 at a clk edge): state=IDLE, tick_cnt=0, bit_cnt=0, shift reg=0; data_out=0, start_bit=0, parity_bit=0, stop_bit=1, def_en=0, rx_busy=0. Reset mid-frame abandons the frame with no def_en pulse.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: on a falling edge (rx_d=1, rx_s=0):
  - go to START;
  - set tick_cnt=0;
  - set rx_busy=1;
  - latch parity_en into par_en_q.
  - A line stuck low does not retrigger; a 1->0 transition is required.
- Bit timing, same rule in every bit state:
  - tick_cnt advances only on clks with baud_tick=1.
  - Mid-bit sample: a baud_tick with tick_cnt==OVERSAMPLE/2-1 (8th tick for 16x) samples rx_s.
  - End of bit: a baud_tick with tick_cnt==OVERSAMPLE-1 wraps tick_cnt to 0 and advances the state.
- START: sample into start_q. A high sample does not abort; the frame is still captured so the checker flags the start error. At end of bit, go to DATA with bit_cnt=0.
- DATA: at each sample, shift rx_s in at the MSB of the shift reg and shift right, so the first bit ends at bit0. At end of bit:
  - if bit_cnt==DATA_BITS-1: go to PARITY when par_en_q=1, otherwise to STOP;
  - else bit_cnt+1.
- PARITY: sample into par_q. At end of bit, go to STOP. With parity disabled, par_q is forced to 0.
- STOP: on the mid-bit sample edge, all of the following happen together (no wait for end of stop bit, which allows back-to-back frames):
  - data_out<=shift reg;
  - start_bit<=start_q;
  - parity_bit<=par_q;
  - stop_bit<=rx_s;
  - def_en<=1;
  - rx_busy<=0;
  - state<=IDLE.
- def_en is high for exactly one clk and is cleared on the next edge.
- data_out, start_bit, parity_bit and stop_bit hold their values until the next def_en. They never change while def_en=0.
- Latency: def_en rises on the clk edge of the stop-bit mid-sample tick, about (1+DATA_BITS+P)*OVERSAMPLE + OVERSAMPLE/2 ticks after the start edge, plus 2 clks of synchroniser delay.
- Stop sampled 0 (break or framing error):
  - def_en still pulses with stop_bit=0;
  - the block returns to IDLE;
  - the next frame requires rx high then falling.
- baud_tick asserted while in IDLE: ignored.
- parity_en changing mid-frame: ignored; it takes effect at the next start detection.

Decomposition:
- Shared package `uart_pkg`: state encoding enum (IDLE/START/DATA/PARITY/STOP), defaults DATA_BITS=8 and OVERSAMPLE=16, and the idle line level constant, all shared with the TX framer.
- One natural sub-module: `uart_rx_sync` (2-FF synchroniser plus edge detect, outputs rx_s and fall). Tick counter, bit counter and FSM stay in the top block.

Test Plan:
1. Byte 0x17 with parity: parity_en=1; drive start 0, data 1,1,1,0,1,0,0,0, parity 0, stop 1; each bit lasts 16 ticks. Expect exactly one def_en pulse with data_out=0x17, start_bit=0, parity_bit=0, stop_bit=1; rx_busy falls on the same edge.
2. Parity disabled: parity_en=0, 10-bit frame of 0xA5. Expect def_en 9.5 bit periods after the start edge, data_out=0xA5, parity_bit=0.
3. Stop error: frame 0x17 with the stop bit driven 0 and the line held low for 3 more bits. Expect a single def_en with stop_bit=0 and no second frame until rx goes high then low.
4. Start glitch: rx low for 3 ticks, then high for the rest of the frame. Expect start_bit=1, data_out=0xFF, parity_bit=1 (parity_en=1), stop_bit=1, one def_en.
5. Back-to-back: 0x17 immediately followed by 0x3C with no idle after the stop mid-sample edge. Expect two def_en pulses with data_out 0x17 then 0x3C.
6. Reset mid-frame: rst=1 for 1 clk during data bit 4. Expect all outputs at their reset values and no def_en. A following clean frame 0x5A is received correctly.
